// File: rtl/slot_pkg.sv
// Shared spin-control types and speed width, also used by the downstream clock divider.
// Saturating helpers work one bit wider than the speed bus so intermediate values never wrap.
package slot_pkg;

    localparam int SPEED_W = 20;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCEL = 2'd1,
        S_HOLD  = 2'd2,
        S_DECEL = 2'd3
    } spin_state_t;

    typedef logic [SPEED_W:0] sat_t;

    function automatic sat_t sat_add(input sat_t a, input sat_t step, input sat_t ceil_v);
        sat_t s;
        s = a + step;
        sat_add = (s >= ceil_v) ? ceil_v : s;
    endfunction

    function automatic sat_t sat_sub(input sat_t a, input sat_t step, input sat_t floor_v);
        sat_sub = (a <= floor_v + step) ? floor_v : a - step;
    endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Free-running 0..RAMP_DIV-1 counter; tick is combinational while the count sits at RAMP_DIV-1.
// clear restarts the count from 0 on the next edge; no backpressure.
module ramp_tick_gen #(
    parameter int RAMP_DIV = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RAMP_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/spin_speed_ctrl.sv
// Spin ramp controller: IDLE -> ACCEL -> HOLD -> DECEL; all outputs registered, speed moves one cycle after a ramp tick.
// Optional SPIN_AUTO_STOP_EN: HOLD ends after the latched hold_ticks ramp ticks; no backpressure.
module spin_speed_ctrl
    import slot_pkg::*;
#(
    parameter int RAMP_DIV  = 2500000,
    parameter int MIN_SPEED = 2,
    parameter int MAX_SPEED = 40,
    parameter int ACC_STEP  = 2,
    parameter int DEC_STEP  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop_req,
    input  logic [7:0]         hold_ticks,
    output logic [SPEED_W-1:0] speed,
    output logic               div_rst,
    output logic               spinning,
    output logic               done
);

    localparam sat_t MIN_W = sat_t'(MIN_SPEED);
    localparam sat_t MAX_W = sat_t'(MAX_SPEED);
    localparam sat_t ACC_W = sat_t'(ACC_STEP);
    localparam sat_t DEC_W = sat_t'(DEC_STEP);

    spin_state_t        state_q, state_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               div_rst_q, div_rst_d;
    logic               done_q, done_d;
    logic               tick, start_acc;
    sat_t               acc_sum, dec_diff;

    assign start_acc = (state_q == S_IDLE) && start;

    ramp_tick_gen #(.RAMP_DIV(RAMP_DIV)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (start_acc),
        .tick  (tick)
    );

    assign acc_sum  = sat_add({1'b0, speed_q}, ACC_W, MAX_W);
    assign dec_diff = sat_sub({1'b0, speed_q}, DEC_W, MIN_W);

`ifdef SPIN_AUTO_STOP_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;
`else
    logic unused_hold_ticks;
    assign unused_hold_ticks = ^hold_ticks;
`endif

    always_comb begin
        state_d   = state_q;
        speed_d   = speed_q;
        div_rst_d = 1'b0;
        done_d    = 1'b0;
`ifdef SPIN_AUTO_STOP_EN
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_ACCEL;
                    speed_d   = MIN_W[SPEED_W-1:0];
                    div_rst_d = 1'b1;
`ifdef SPIN_AUTO_STOP_EN
                    hold_cnt_d = (hold_ticks == 8'd0) ? 8'd1 : hold_ticks;
`endif
                end
            end
            S_ACCEL: begin
                // A stop request takes priority over a coincident tick: speed holds on that edge.
                if (stop_req) begin
                    state_d = S_DECEL;
                end else if (tick) begin
                    speed_d = acc_sum[SPEED_W-1:0];
                    if (acc_sum == MAX_W) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (stop_req) begin
                    state_d = S_DECEL;
                end
`ifdef SPIN_AUTO_STOP_EN
                else if (tick) begin
                    if (hold_cnt_q <= 8'd1) begin
                        state_d = S_DECEL;
                    end else begin
                        hold_cnt_d = hold_cnt_q - 8'd1;
                    end
                end
`endif
            end
            S_DECEL: begin
                if (tick) begin
                    speed_d = dec_diff[SPEED_W-1:0];
                    if (dec_diff == MIN_W) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            speed_q   <= MIN_W[SPEED_W-1:0];
            div_rst_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            speed_q   <= speed_d;
            div_rst_q <= div_rst_d;
            done_q    <= done_d;
        end
    end

`ifdef SPIN_AUTO_STOP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= 8'd0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`endif

    assign speed    = speed_q;
    assign div_rst  = div_rst_q;
    assign done     = done_q;
    assign spinning = (state_q != S_IDLE);

endmodule
